// File: rtl/divider_pipelined_param_if.sv
// Handshake/data bundle for divider_pipelined_param.
// Optional exception-flag outputs appear when DIVIDER_PIPELINED_EXC_FLAGS_EN is defined.
interface divider_pipelined_param_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic             stall;
  logic             flush;
  logic             i_valid;
  logic             i_signed;
  logic [TAG_W-1:0] i_tag;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_valid;
  logic [TAG_W-1:0] o_tag;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
  logic             o_div_zero;
  logic             o_overflow;
`endif

  // Producer side (decode / testbench)
  modport master (
    output stall, flush, i_valid, i_signed, i_tag, i_dividend, i_divisor,
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
    input  o_div_zero, o_overflow,
`endif
    input  o_valid, o_tag, o_quotient, o_remainder
  );

  // Divider side
  modport slave (
    input  stall, flush, i_valid, i_signed, i_tag, i_dividend, i_divisor,
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
    output o_div_zero, o_overflow,
`endif
    output o_valid, o_tag, o_quotient, o_remainder
  );
endinterface

// File: rtl/divider_pipelined_param.sv
// Parametrised pipelined restoring divider (DIV/DIVU/REM/REMU, RISC-V corner cases).
// STAGES = WIDTH/ITERS_PER_STAGE stages, STAGES-1 register banks, latency STAGES-1 cycles.
// WIDTH must be a multiple of ITERS_PER_STAGE with STAGES >= 2.
// Optional macro DIVIDER_PIPELINED_EXC_FLAGS_EN adds o_div_zero / o_overflow outputs.
module divider_pipelined_param #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned ITERS_PER_STAGE = 4,
  parameter int unsigned TAG_W           = 5
) (
  input logic                      clk,
  input logic                      rst,
  divider_pipelined_param_if.slave bus
);

  localparam int unsigned STAGES = WIDTH / ITERS_PER_STAGE;
  localparam int unsigned BANKS  = STAGES - 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             sgn;
    logic             q_neg;
    logic             r_neg;
    logic             dz;
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
    logic             ovf;
`endif
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
  } bank_t;

  // ITERS_PER_STAGE restoring iterations; the shifted remainder needs one extra bit
  // because it can exceed WIDTH bits when the divisor is large.
  function automatic bank_t run_iters(input bank_t b);
    bank_t          o;
    logic [WIDTH:0] sh;
    o = b;
    for (int unsigned i = 0; i < ITERS_PER_STAGE; i++) begin
      sh         = {o.rem, o.dividend[WIDTH-1]};
      o.dividend = o.dividend << 1;
      if (sh >= {1'b0, o.divisor}) begin
        sh    = sh - {1'b0, o.divisor};
        o.quo = {o.quo[WIDTH-2:0], 1'b1};
      end else begin
        o.quo = {o.quo[WIDTH-2:0], 1'b0};
      end
      o.rem = sh[WIDTH-1:0];
    end
    return o;
  endfunction

  // Final stage only needs the magnitude quotient and remainder.
  function automatic logic [2*WIDTH-1:0] final_qr(input bank_t b);
    bank_t o;
    o = run_iters(b);
    return {o.quo, o.rem};
  endfunction

  bank_t            s0;
  bank_t            bank_d [BANKS];
  bank_t            bank_q [BANKS];
  bank_t            last;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] r_raw;

  assign a_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
  assign b_neg = bus.i_signed & bus.i_divisor[WIDTH-1];

  // Stage 0 pre-processing: magnitudes, result signs and exception flags.
  // Negating MIN leaves MIN, which is the correct unsigned magnitude 2^(WIDTH-1).
  always_comb begin
    s0          = '0;
    s0.valid    = bus.i_valid;
    s0.tag      = bus.i_tag;
    s0.sgn      = bus.i_signed;
    s0.dividend = a_neg ? -bus.i_dividend : bus.i_dividend;
    s0.divisor  = b_neg ? -bus.i_divisor : bus.i_divisor;
    s0.dz       = (bus.i_divisor == '0);
    s0.q_neg    = (a_neg ^ b_neg) & ~s0.dz;
    s0.r_neg    = a_neg;
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
    s0.ovf      = bus.i_signed && (bus.i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                  && (&bus.i_divisor);
`endif
  end

  assign bank_d[0] = run_iters(s0);

  for (genvar k = 1; k < BANKS; k++) begin : g_stage
    assign bank_d[k] = run_iters(bank_q[k-1]);
  end

  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    // Bank register: reset clears everything, flush kills validity, stall freezes.
    always_ff @(posedge clk) begin
      if (rst) begin
        bank_q[k] <= '0;
      end else if (bus.flush) begin
        bank_q[k].valid <= 1'b0;
      end else if (!bus.stall) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  assign last           = bank_q[BANKS-1];
  assign {q_raw, r_raw} = final_qr(last);

  // Final stage post-processing and output gating on validity.
  always_comb begin
    bus.o_valid     = last.valid;
    bus.o_tag       = '0;
    bus.o_quotient  = '0;
    bus.o_remainder = '0;
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
    bus.o_div_zero  = 1'b0;
    bus.o_overflow  = 1'b0;
`endif
    if (last.valid) begin
      bus.o_tag       = last.tag;
      // Divide-by-zero always yields all ones; q_neg is already clear in that case.
      bus.o_quotient  = last.dz ? '1 : ((last.sgn & last.q_neg) ? -q_raw : q_raw);
      bus.o_remainder = (last.sgn & last.r_neg) ? -r_raw : r_raw;
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
      bus.o_div_zero  = last.dz;
      bus.o_overflow  = last.ovf;
`endif
    end
  end

endmodule

// File: tb/tb_divider_pipelined_param.sv
// Self-checking bench for divider_pipelined_param: default 32/4 plus 16/2 and 8/4 builds.
// Honours DIVIDER_PIPELINED_EXC_FLAGS_EN when defined.
module tb_divider_pipelined_param;

  logic   clk = 1'b0;
  logic   rst;
  integer checks = 0;
  integer errors = 0;

  always #5 clk = ~clk;

  divider_pipelined_param_if #(.WIDTH(32), .TAG_W(5)) bus32 ();
  divider_pipelined_param_if #(.WIDTH(16), .TAG_W(5)) bus16 ();
  divider_pipelined_param_if #(.WIDTH(8),  .TAG_W(5)) bus8 ();

  divider_pipelined_param #(.WIDTH(32), .ITERS_PER_STAGE(4), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );
  divider_pipelined_param #(.WIDTH(16), .ITERS_PER_STAGE(2), .TAG_W(5)) u_dut16 (
    .clk(clk), .rst(rst), .bus(bus16)
  );
  divider_pipelined_param #(.WIDTH(8), .ITERS_PER_STAGE(4), .TAG_W(5)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic s, input logic [4:0] t,
                         input logic [31:0] a, input logic [31:0] b);
    bus32.i_valid    = v;
    bus32.i_signed   = s;
    bus32.i_tag      = t;
    bus32.i_dividend = a;
    bus32.i_divisor  = b;
  endtask

  task automatic idle_all();
    drive32(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    bus32.stall = 1'b0; bus32.flush = 1'b0;
    bus16.stall = 1'b0; bus16.flush = 1'b0; bus16.i_valid = 1'b0; bus16.i_signed = 1'b0;
    bus16.i_tag = '0; bus16.i_dividend = '0; bus16.i_divisor = '0;
    bus8.stall = 1'b0; bus8.flush = 1'b0; bus8.i_valid = 1'b0; bus8.i_signed = 1'b0;
    bus8.i_tag = '0; bus8.i_dividend = '0; bus8.i_divisor = '0;
  endtask

  // Reference: w-bit operands, RISC-V semantics via 64-bit signed arithmetic. Returns {q, r}.
  function automatic logic [63:0] ref_div(input int w, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, qq, rr;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    sa = {32'h0, a & mask};
    sb = {32'h0, b & mask};
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    if ((b & mask) == 32'h0) return {mask, a & mask};
    qq = sa / sb;
    rr = sa % sb;
    return {qq[31:0] & mask, rr[31:0] & mask};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus32.o_valid, bus32.o_tag, bus32.o_quotient, bus32.o_remainder} !== '0) begin
      errors++;
      $display("FAIL reset32 got v=%b tag=%0d q=%h r=%h want all 0", bus32.o_valid,
               bus32.o_tag, bus32.o_quotient, bus32.o_remainder);
    end
    checks++;
    if ({bus16.o_valid, bus16.o_tag, bus16.o_quotient, bus16.o_remainder,
         bus8.o_valid, bus8.o_tag, bus8.o_quotient, bus8.o_remainder} !== '0) begin
      errors++;
      $display("FAIL reset_sweep got v16=%b v8=%b q16=%h q8=%h want all 0",
               bus16.o_valid, bus8.o_valid, bus16.o_quotient, bus8.o_quotient);
    end
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
    checks++;
    if ({bus32.o_div_zero, bus32.o_overflow} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got dz=%b ovf=%b want 0 0", bus32.o_div_zero, bus32.o_overflow);
    end
`endif
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [3], tb [3], eq [3], er [3];
    logic [4:0]  tg [3];
    logic        exp_v;
    ta = '{32'd100, 32'hFFFF_FFFF, 32'd5};
    tb = '{32'd7, 32'd1, 32'd10};
    eq = '{32'd14, 32'hFFFF_FFFF, 32'd0};
    er = '{32'd2, 32'd0, 32'd5};
    tg = '{5'd1, 5'd2, 5'd3};
    for (int c = 0; c < 13; c++) begin
      if (c < 3) drive32(1'b1, 1'b0, tg[c], ta[c], tb[c]);
      else drive32(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      exp_v = (c >= 7) && (c <= 9);
      checks++;
      if (bus32.o_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid cycle %0d got %b want %b", c, bus32.o_valid, exp_v);
      end
      checks++;
      if (exp_v) begin
        if (bus32.o_tag !== tg[c-7] || bus32.o_quotient !== eq[c-7] ||
            bus32.o_remainder !== er[c-7]) begin
          errors++;
          $display("FAIL b2b_result cycle %0d got tag=%0d q=%h r=%h want tag=%0d q=%h r=%h",
                   c, bus32.o_tag, bus32.o_quotient, bus32.o_remainder,
                   tg[c-7], eq[c-7], er[c-7]);
        end
      end else if ({bus32.o_tag, bus32.o_quotient, bus32.o_remainder} !== '0) begin
        errors++;
        $display("FAIL b2b_gating cycle %0d got tag=%0d q=%h r=%h want 0", c, bus32.o_tag,
                 bus32.o_quotient, bus32.o_remainder);
      end
      next_cycle();
    end
  endtask

  task automatic test_signed();
    logic [31:0] ta [3], tb [3], eq [3], er [3];
    logic        ovf [3];
    logic        exp_v;
    ta  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    tb  = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    eq  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    er  = '{32'hFFFF_FFFF, 32'd1, 32'd0};
    ovf = '{1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 12; c++) begin
      if (c < 3) drive32(1'b1, 1'b1, 5'(4 + c), ta[c], tb[c]);
      else drive32(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      exp_v = (c >= 7) && (c <= 9);
      checks++;
      if (bus32.o_valid !== exp_v) begin
        errors++;
        $display("FAIL signed_valid cycle %0d got %b want %b", c, bus32.o_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (bus32.o_tag !== 5'(c - 3) || bus32.o_quotient !== eq[c-7] ||
            bus32.o_remainder !== er[c-7]) begin
          errors++;
          $display("FAIL signed_result op%0d got tag=%0d q=%h r=%h want tag=%0d q=%h r=%h",
                   c - 7, bus32.o_tag, bus32.o_quotient, bus32.o_remainder, c - 3,
                   eq[c-7], er[c-7]);
        end
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
        checks++;
        if (bus32.o_overflow !== ovf[c-7] || bus32.o_div_zero !== 1'b0) begin
          errors++;
          $display("FAIL signed_flags op%0d got ovf=%b dz=%b want ovf=%b dz=0", c - 7,
                   bus32.o_overflow, bus32.o_div_zero, ovf[c-7]);
        end
`endif
      end
      next_cycle();
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] ta [2], er [2];
    logic        sg [2];
    logic        exp_v;
    ta = '{32'd42, 32'hFFFF_FFD6};
    er = '{32'd42, 32'hFFFF_FFD6};
    sg = '{1'b0, 1'b1};
    for (int c = 0; c < 11; c++) begin
      if (c < 2) drive32(1'b1, sg[c], 5'(7 + c), ta[c], 32'd0);
      else drive32(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      exp_v = (c >= 7) && (c <= 8);
      checks++;
      if (bus32.o_valid !== exp_v) begin
        errors++;
        $display("FAIL divzero_valid cycle %0d got %b want %b", c, bus32.o_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (bus32.o_tag !== 5'(c) || bus32.o_quotient !== 32'hFFFF_FFFF ||
            bus32.o_remainder !== er[c-7]) begin
          errors++;
          $display("FAIL divzero_result op%0d got tag=%0d q=%h r=%h want tag=%0d q=ffffffff r=%h",
                   c - 7, bus32.o_tag, bus32.o_quotient, bus32.o_remainder, c, er[c-7]);
        end
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
        checks++;
        if (bus32.o_div_zero !== 1'b1 || bus32.o_overflow !== 1'b0) begin
          errors++;
          $display("FAIL divzero_flags op%0d got dz=%b ovf=%b want dz=1 ovf=0", c - 7,
                   bus32.o_div_zero, bus32.o_overflow);
        end
`endif
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic exp_v;
    for (int c = 0; c < 15; c++) begin
      bus32.stall = (c >= 3) && (c <= 5);
      if (c == 0) drive32(1'b1, 1'b0, 5'd9, 32'd100, 32'd7);
      else if (bus32.stall) drive32(1'b1, 1'b0, 5'd10, 32'd50, 32'd5);
      else drive32(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      exp_v = (c == 10);
      checks++;
      if (bus32.o_valid !== exp_v) begin
        errors++;
        $display("FAIL stall_valid cycle %0d got %b want %b (tag=%0d)", c, bus32.o_valid,
                 exp_v, bus32.o_tag);
      end
      if (exp_v) begin
        checks++;
        if (bus32.o_tag !== 5'd9 || bus32.o_quotient !== 32'd14 ||
            bus32.o_remainder !== 32'd2) begin
          errors++;
          $display("FAIL stall_result got tag=%0d q=%h r=%h want tag=9 q=e r=2", bus32.o_tag,
                   bus32.o_quotient, bus32.o_remainder);
        end
      end
      next_cycle();
    end
    bus32.stall = 1'b0;
  endtask

  // Pass 0: plain flush. Pass 1: flush asserted while stalled.
  task automatic test_flush();
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 13; c++) begin
        bus32.flush = (c == 4);
        bus32.stall = (p == 1) && (c >= 3) && (c <= 4);
        if (c <= 4) drive32(1'b1, 1'b0, 5'(11 + c), 32'd81, 32'd9);
        else drive32(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (bus32.o_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_pass%0d cycle %0d got o_valid=%b tag=%0d want 0", p, c,
                   bus32.o_valid, bus32.o_tag);
        end
        next_cycle();
      end
    end
    bus32.flush = 1'b0;
    bus32.stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 13; c++) begin
      rst = (c == 4);
      if (c < 4) drive32(1'b1, 1'b1, 5'(20 + c), 32'hFFFF_FF00, 32'd3);
      else drive32(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      checks++;
      if (bus32.o_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_valid cycle %0d got %b want 0", c, bus32.o_valid);
      end
      if (c == 5) begin
        checks++;
        if ({bus32.o_tag, bus32.o_quotient, bus32.o_remainder} !== '0) begin
          errors++;
          $display("FAIL rstmid_outputs got tag=%0d q=%h r=%h want 0", bus32.o_tag,
                   bus32.o_quotient, bus32.o_remainder);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_param_sweep();
    logic        v16 [60], s16 [60], v8 [60], s8 [60];
    logic [15:0] a16 [60], b16 [60];
    logic [7:0]  a8 [60], b8 [60];
    logic [63:0] res;
    int          sel, i16, i8;
    for (int c = 0; c < 70; c++) begin
      if (c < 60) begin
        v16[c] = ($urandom_range(0, 3) != 0);
        s16[c] = 1'($urandom_range(0, 1));
        a16[c] = 16'($urandom);
        sel    = $urandom_range(0, 7);
        b16[c] = (sel == 0) ? 16'h0 : (sel == 1) ? 16'hFFFF :
                 (sel == 2) ? 16'($urandom_range(1, 5)) : 16'($urandom);
        if (sel == 1) begin a16[c] = 16'h8000; s16[c] = 1'b1; end
        v8[c] = ($urandom_range(0, 3) != 0);
        s8[c] = 1'($urandom_range(0, 1));
        a8[c] = 8'($urandom);
        sel   = $urandom_range(0, 7);
        b8[c] = (sel == 0) ? 8'h0 : (sel == 1) ? 8'hFF :
                (sel == 2) ? 8'($urandom_range(1, 5)) : 8'($urandom);
        if (sel == 1) begin a8[c] = 8'h80; s8[c] = 1'b1; end
        bus16.i_valid = v16[c]; bus16.i_signed = s16[c]; bus16.i_tag = 5'(c);
        bus16.i_dividend = a16[c]; bus16.i_divisor = b16[c];
        bus8.i_valid = v8[c]; bus8.i_signed = s8[c]; bus8.i_tag = 5'(c);
        bus8.i_dividend = a8[c]; bus8.i_divisor = b8[c];
      end else begin
        bus16.i_valid = 1'b0;
        bus8.i_valid  = 1'b0;
      end
      @(negedge clk);
      i16 = c - 7;
      checks++;
      if (i16 >= 0 && i16 < 60 && v16[i16]) begin
        res = ref_div(16, s16[i16], {16'h0, a16[i16]}, {16'h0, b16[i16]});
        if (bus16.o_valid !== 1'b1 || bus16.o_tag !== 5'(i16) ||
            {16'h0, bus16.o_quotient} !== res[63:32] ||
            {16'h0, bus16.o_remainder} !== res[31:0]) begin
          errors++;
          $display("FAIL sweep16 op%0d s=%b %h/%h got v=%b tag=%0d q=%h r=%h want q=%h r=%h",
                   i16, s16[i16], a16[i16], b16[i16], bus16.o_valid, bus16.o_tag,
                   bus16.o_quotient, bus16.o_remainder, res[47:32], res[15:0]);
        end
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
        checks++;
        if (bus16.o_div_zero !== (b16[i16] == 16'h0) ||
            bus16.o_overflow !== (s16[i16] && a16[i16] == 16'h8000 && b16[i16] == 16'hFFFF))
        begin
          errors++;
          $display("FAIL sweep16_flags op%0d got dz=%b ovf=%b", i16, bus16.o_div_zero,
                   bus16.o_overflow);
        end
`endif
      end else if (bus16.o_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep16_bubble cycle %0d got o_valid=%b want 0", c, bus16.o_valid);
      end
      i8 = c - 1;
      checks++;
      if (i8 >= 0 && i8 < 60 && v8[i8]) begin
        res = ref_div(8, s8[i8], {24'h0, a8[i8]}, {24'h0, b8[i8]});
        if (bus8.o_valid !== 1'b1 || bus8.o_tag !== 5'(i8) ||
            {24'h0, bus8.o_quotient} !== res[63:32] ||
            {24'h0, bus8.o_remainder} !== res[31:0]) begin
          errors++;
          $display("FAIL sweep8 op%0d s=%b %h/%h got v=%b tag=%0d q=%h r=%h want q=%h r=%h",
                   i8, s8[i8], a8[i8], b8[i8], bus8.o_valid, bus8.o_tag,
                   bus8.o_quotient, bus8.o_remainder, res[39:32], res[7:0]);
        end
`ifdef DIVIDER_PIPELINED_EXC_FLAGS_EN
        checks++;
        if (bus8.o_div_zero !== (b8[i8] == 8'h0) ||
            bus8.o_overflow !== (s8[i8] && a8[i8] == 8'h80 && b8[i8] == 8'hFF)) begin
          errors++;
          $display("FAIL sweep8_flags op%0d got dz=%b ovf=%b", i8, bus8.o_div_zero,
                   bus8.o_overflow);
        end
`endif
      end else if (bus8.o_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep8_bubble cycle %0d got o_valid=%b want 0", c, bus8.o_valid);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    next_cycle();
    test_reset();
    test_back_to_back();
    test_signed();
    test_div_zero();
    test_stall();
    test_flush();
    test_reset_mid();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider_pipelined_param.md
Name: divider_pipelined_param

Overview:
- Parametrised successor to the fixed 32-bit, 8-stage unsigned pipelined divider.
- Configurable width and iterations per stage.
- Adds:
  - valid/tag tracking through the pipe.
  - flush.
  - signed (DIV/REM) and unsigned (DIVU/REMU) modes with RISC-V corner-case semantics.
- Sits in the execute stage of the multicycle/pipelined core, fed by decode, drained by writeback.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ITERS_PER_STAGE, 4, restoring-division iterations evaluated combinationally per stage. Must divide WIDTH; STAGES = WIDTH/ITERS_PER_STAGE >= 2.
- TAG_W, 5, width of the sideband tag (e.g. destination register index).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  freeze all pipeline registers.
- flush  input  1  kill all in-flight operations.
- i_valid  input  1  operation presented this cycle.
- i_signed  input  1  1 = signed DIV/REM, 0 = DIVU/REMU.
- i_tag  input  TAG_W  sideband carried with the operation.
- i_dividend  input  WIDTH  dividend.
- i_divisor  input  WIDTH  divisor.
- o_valid  output  1  result valid this cycle.
- o_tag  output  TAG_W  tag of the result.
- o_quotient  output  WIDTH  quotient.
- o_remainder  output  WIDTH  remainder.

Behaviour:
- Structure:
  - STAGES stages of ITERS_PER_STAGE divu iterations each.
  - STAGES-1 register banks sit between stages.
  - Stage 0 is combinational from the inputs; the final stage is combinational from the last bank.
- Each bank holds: valid, tag, signed flag, quotient sign, remainder sign, divisor-zero flag, shifted dividend, partial remainder, partial quotient, divisor.
- Latency: operation presented with i_valid=1 in cycle t (stall=0) appears with o_valid=1 in cycle t+STAGES-1 (7 for defaults). Throughput is 1 op/cycle.
- Iteration (WIDTH-bit arithmetic):
  - rem' = (rem<<1) | dividend[MSB]; dividend' = dividend<<1.
  - If rem' >= divisor: rem' -= divisor, quotient = (quotient<<1)|1.
  - Otherwise: quotient = quotient<<1.
- Signed pre-processing in stage 0:
  - Operands replaced by their magnitudes (two's-complement negate if MSB set; MIN stays MIN as unsigned 2^(WIDTH-1)).
  - q_neg = sign(dividend) XOR sign(divisor), AND divisor != 0.
  - r_neg = sign(dividend).
- Unsigned mode: q_neg = r_neg = 0.
- Post-processing in the final stage: quotient negated if q_neg; remainder negated if r_neg.
- Required corner results, which fall out of the above and must hold:
  - x/0: quotient = all ones; remainder = x (both modes).
  - Signed MIN/-1: quotient = MIN, remainder = 0.
- Stall=1: no bank updates, inputs ignored (i_valid not captured). Outputs hold their values combinationally.
- Flush=1: every bank valid bit cleared at the next edge. Priority rst > flush > stall.
  - Flush during stall still clears.
  - An input presented in the flush cycle is dropped.
- Output gating: o_tag, o_quotient and o_remainder are forced to 0 whenever o_valid=0.
- Reset: all valid bits and all datapath registers cleared next edge.
  - o_valid=0, o_tag=0, o_quotient=0, o_remainder=0.
  - Reset mid-operation discards all in-flight ops; no result ever emerges for them.
- Bubbles (i_valid=0) propagate as invalid entries; the datapath contents of invalid entries are don't-care but never visible due to gating.

Optional Feature:
- Macro DIVIDER_PIPELINED_EXC_FLAGS_EN.
- When defined, adds two outputs:
  - o_div_zero  output  1: divisor was 0.
  - o_overflow  output  1: signed MIN/-1.
- Both flags are computed in stage 0, carried through every bank with the tag, and gated by o_valid (0 otherwise, 0 after reset).
- When undefined: ports absent, no extra registers, results identical.

Test Plan:
- Unsigned back-to-back, defaults: (100,7), (0xFFFFFFFF,1), (5,10) in cycles 0,1,2.
  - Required: o_valid cycles 7,8,9.
  - Results q/r = 14/2, 0xFFFFFFFF/0, 0/5.
  - Tags match inputs.
- Signed:
  - -7/2 -> q=-3 (0xFFFFFFFD), r=-1.
  - 7/-2 -> q=-3, r=1.
  - 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0 (o_overflow=1 if enabled).
- Divide by zero:
  - unsigned 42/0 -> q=0xFFFFFFFF, r=42.
  - signed -42/0 -> q=0xFFFFFFFF, r=0xFFFFFFD6 (o_div_zero=1 if enabled).
- Stall: issue op at cycle 0, stall=1 in cycles 3-5, i_valid=1 with a different op during stall.
  - Required: result appears cycle 10.
  - Stalled-cycle input never emerges.
- Flush and reset:
  - Issue ops cycles 0-3, flush in cycle 4: no o_valid in cycles 4-12.
  - Repeat with rst instead of flush: same.
  - All outputs 0 the cycle after rst.
- Parameter sweep: WIDTH=16/ITERS_PER_STAGE=2 and WIDTH=8/ITERS_PER_STAGE=4.
  - Latencies 7 and 1 cycles.
  - Random operands, both modes, checked against a reference model.
